// File: rtl/keccak_iota_seq.sv
// keccak_iota_seq: round sequencer and iota XOR stage for the slice-parallel Keccak-f[1600] datapath.
// Define KECCAK_IOTA_ABORT_EN to add the abort input that cancels a permutation in flight.
module keccak_iota_seq #(
   parameter int unsigned PARALLEL_SLICES   = 16,
   parameter int unsigned NUM_SUB_ROUNDS    = 64 / PARALLEL_SLICES,
   parameter int unsigned ROUND_COUNT_WIDTH = $clog2(25 * NUM_SUB_ROUNDS),
   parameter int unsigned MAX_ROUND_COUNT   = 25 * NUM_SUB_ROUNDS - 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
`ifdef KECCAK_IOTA_ABORT_EN
   input  logic                         abort,
`endif
   output logic                         busy,
   output logic                         done,
   output logic [ROUND_COUNT_WIDTH-1:0] rc_idx,
   input  logic [PARALLEL_SLICES-1:0]   rc_in,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [PARALLEL_SLICES-1:0]   in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PARALLEL_SLICES-1:0]   out_data
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ROUND_COUNT_WIDTH-1:0] K_FIRST = ROUND_COUNT_WIDTH'(NUM_SUB_ROUNDS);
   localparam logic [ROUND_COUNT_WIDTH-1:0] K_LAST  = ROUND_COUNT_WIDTH'(MAX_ROUND_COUNT);
   localparam logic [ROUND_COUNT_WIDTH-1:0] K_ONE   = ROUND_COUNT_WIDTH'(1);

   logic [1:0]                   state_q;
   logic [1:0]                   state_nxt;
   logic [ROUND_COUNT_WIDTH-1:0] k_q;
   logic [ROUND_COUNT_WIDTH-1:0] k_nxt;
   logic                         accept_c;
   logic                         abort_c;
   logic                         abort_hit_c;

`ifdef KECCAK_IOTA_ABORT_EN
   assign abort_c = abort;
`else
   assign abort_c = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_nxt;
   end

   // Next state, step counter update and ROM index selection
   always_comb begin
      state_nxt   = state_q;
      k_nxt       = k_q;
      rc_idx      = K_LAST;
      in_ready    = 1'b0;
      accept_c    = 1'b0;
      abort_hit_c = abort_c && ((state_q == S_RUN) || (state_q == S_FLUSH));
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_RUN;
               k_nxt     = K_FIRST;
               rc_idx    = K_FIRST - K_ONE;
            end
         end
         S_RUN: begin
            in_ready = !out_valid || out_ready;
            accept_c = in_valid && in_ready && !abort_c;
            // Prefetch the next constant on accept, otherwise keep the ROM pointed at the current one
            if (accept_c) begin
               rc_idx = k_q;
               if (k_q == K_LAST) state_nxt = S_FLUSH;
               else               k_nxt     = k_q + K_ONE;
            end else begin
               rc_idx = k_q - K_ONE;
            end
         end
         S_FLUSH: begin
            if (out_valid && out_ready) state_nxt = S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (abort_hit_c) state_nxt = S_IDLE;
      if (rst) rc_idx = K_LAST;
   end

   // Step counter, iota output register and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         k_q       <= K_FIRST;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         k_q  <= k_nxt;
         busy <= (state_nxt == S_RUN) || (state_nxt == S_FLUSH);
         done <= (state_nxt == S_DONE);
         if (abort_hit_c) begin
            out_valid <= 1'b0;
         end else if (accept_c) begin
            out_valid <= 1'b1;
            out_data  <= in_data ^ rc_in;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
